// File: rtl/perip_timer_cmp_pkg.sv
// Shared register map and constants for the memory-mapped machine timer.
package perip_timer_cmp_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        TIMER_MTIME_LO = 2'd0,
        TIMER_MTIME_HI = 2'd1,
        TIMER_CMP_LO   = 2'd2,
        TIMER_CMP_HI   = 2'd3
    } timer_reg_e;

    localparam logic [63:0] TIMER_CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/perip_timer_cmp_if.sv
// Peripheral bus seen by the timer: one access per cycle while ena is high, plus the irq level.
interface perip_timer_cmp_if;
    import perip_timer_cmp_pkg::*;

    logic              ena;
    logic              rw;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              irq;

    modport master (output ena, rw, addr, wdata, input rdata, irq);
    modport slave  (input ena, rw, addr, wdata, output rdata, irq);

endinterface

// File: rtl/perip_timer_cmp_tick.sv
// Prescaler producing a one-cycle enable pulse every CLK_DIV clocks (the 1 us time base).
module perip_timer_tick #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] prescaler;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    assign tick = (prescaler == LAST);

endmodule

// File: rtl/perip_timer_cmp.sv
// Machine timer: 64-bit mtime/mtimecmp behind a 32-bit bus, atomic mtime read snapshot, level irq.
module perip_timer_cmp
    import perip_timer_cmp_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic              clk,
    input  logic              rst,
    perip_timer_cmp_if.slave  bus
);

    logic              tick;
    logic [63:0]       mtime;
    logic [63:0]       mtimecmp;
    logic [DATA_W-1:0] shadow_hi;
    logic [DATA_W-1:0] rdata;
    logic              irq;
    timer_reg_e        sel;
    logic              wr_en;
    logic              rd_en;
    logic              unused_addr_bits;

    perip_timer_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign sel              = timer_reg_e'(bus.addr[3:2]);
    assign wr_en            = bus.ena & bus.rw;
    assign rd_en            = bus.ena & ~bus.rw;
    assign unused_addr_bits = ^{bus.addr[DATA_W-1:4], bus.addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime     <= '0;
            mtimecmp  <= TIMER_CMP_RESET;
            shadow_hi <= '0;
            rdata     <= '0;
            irq       <= 1'b0;
        end else begin
            // A write to either mtime half overrides that cycle's tick; the other half is untouched.
            if (wr_en && sel == TIMER_MTIME_LO) begin
                mtime[31:0] <= bus.wdata;
            end else if (wr_en && sel == TIMER_MTIME_HI) begin
                mtime[63:32] <= bus.wdata;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (wr_en && sel == TIMER_CMP_LO) begin
                mtimecmp[31:0] <= bus.wdata;
            end
            if (wr_en && sel == TIMER_CMP_HI) begin
                mtimecmp[63:32] <= bus.wdata;
            end

            // Reading the low half latches the high half so a two-read sequence is coherent.
            if (rd_en) begin
                case (sel)
                    TIMER_MTIME_LO: begin
                        rdata     <= mtime[31:0];
                        shadow_hi <= mtime[63:32];
                    end
                    TIMER_MTIME_HI: rdata <= shadow_hi;
                    TIMER_CMP_LO:   rdata <= mtimecmp[31:0];
                    TIMER_CMP_HI:   rdata <= mtimecmp[63:32];
                endcase
            end

            irq <= (mtime >= mtimecmp);
        end
    end

    assign bus.rdata = rdata;
    assign bus.irq   = irq;

endmodule
